sweep_sequencer: RTL and testbench

//  Sequences the 4-bit LED up/down counter datapath from two front-panel buttons.

---
 rtl/sweep_sequencer_if.sv | 30 +++
 rtl/sweep_sequencer.sv | 175 +++++++++++++++++
 tb/tb_sweep_sequencer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/sweep_sequencer_if.sv
// ============================================================================
// Module  : sweep_sequencer_if
// Brief   : Button inputs and LED/status outputs of the sweep sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface sweep_sequencer_if #(
    parameter int WIDTH = 4
);
    logic             go_btn;
    logic             pause_btn;
    logic [WIDTH-1:0] led;
    logic             busy;
    logic             dir;
    logic             done;
    logic [7:0]       sweep_cnt;

    modport master (
        output go_btn, pause_btn,
        input  led, busy, dir, done, sweep_cnt
    );

    modport slave (
        input  go_btn, pause_btn,
        output led, busy, dir, done, sweep_cnt
    );
endinterface

`default_nettype wire

// File: rtl/sweep_sequencer.sv
// ============================================================================
// Module  : sweep_sequencer
// Brief   : Button-driven up/down LED sweep with pause, prescaled steps and a
//           bounded sweep count. Optional button debounce: SWEEP_DEBOUNCE_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sweep_sequencer #(
    parameter int WIDTH    = 4,
    parameter int TICK_DIV = 1500000,
    parameter int SWEEPS   = 3
`ifdef SWEEP_DEBOUNCE_EN
    ,
    parameter int DEBOUNCE_CYCLES = 65536
`endif
) (
    input  wire logic            clk,
    input  wire logic            rst_btn,
    sweep_sequencer_if.slave     bus
);

    localparam int               c_pw        = $clog2(TICK_DIV);
    localparam logic [c_pw-1:0]  c_tick_last = c_pw'(TICK_DIV - 1);
    localparam logic [WIDTH-1:0] c_led_max   = '1;
    localparam logic [7:0]       c_sweeps    = 8'(SWEEPS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_UP    = 2'd1,
        S_DOWN  = 2'd2,
        S_PAUSE = 2'd3
    } state_t;

    // Button index 0 = go, 1 = pause. Synchronizers idle at the released level.
    logic [1:0] r_sync1;
    logic [1:0] r_sync2;
    logic [1:0] r_level_d;
    logic [1:0] w_level;
    logic [1:0] w_press;

    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            r_sync1   <= 2'b11;
            r_sync2   <= 2'b11;
            r_level_d <= 2'b11;
        end else begin
            r_sync1   <= {bus.pause_btn, bus.go_btn};
            r_sync2   <= r_sync1;
            r_level_d <= w_level;
        end
    end

`ifdef SWEEP_DEBOUNCE_EN
    localparam int c_dw = $clog2(DEBOUNCE_CYCLES + 1);

    for (genvar i = 0; i < 2; i++) begin : g_btn_debounce
        logic [c_dw-1:0] r_cnt;
        logic            r_deb;

        always_ff @(posedge clk or negedge rst_btn) begin
            if (!rst_btn) begin
                r_cnt <= '0;
                r_deb <= 1'b1;
            end else if (r_sync2[i] == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == c_dw'(DEBOUNCE_CYCLES - 1)) begin
                r_cnt <= '0;
                r_deb <= r_sync2[i];
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign w_level[i] = r_deb;
    end
`else
    assign w_level = r_sync2;
`endif

    // Active-low pins: a press is the released->pressed transition.
    assign w_press = ~w_level & r_level_d;

    state_t           r_state,   w_state_nxt;
    logic [WIDTH-1:0] r_led,     w_led_nxt;
    logic [c_pw-1:0]  r_presc,   w_presc_nxt;
    logic [7:0]       r_sweep,   w_sweep_nxt;
    logic             r_saved_up, w_saved_up_nxt;
    logic             r_done,    w_done_nxt;
    logic             w_dir;
    logic             w_tick;
    logic [7:0]       w_sweep_inc;

    assign w_tick      = (r_presc == c_tick_last);
    assign w_sweep_inc = (r_sweep == 8'hFF) ? r_sweep : r_sweep + 8'd1;

    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            r_state    <= S_IDLE;
            r_led      <= '0;
            r_presc    <= '0;
            r_sweep    <= '0;
            r_saved_up <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_led      <= w_led_nxt;
            r_presc    <= w_presc_nxt;
            r_sweep    <= w_sweep_nxt;
            r_saved_up <= w_saved_up_nxt;
            r_done     <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_led_nxt      = r_led;
        w_presc_nxt    = r_presc;
        w_sweep_nxt    = r_sweep;
        w_saved_up_nxt = r_saved_up;
        w_done_nxt     = 1'b0;
        w_dir          = 1'b1;

        case (r_state)
            S_IDLE: begin
                w_led_nxt = '0;
                if (w_press[0]) begin
                    w_state_nxt = S_UP;
                    w_presc_nxt = '0;
                    w_sweep_nxt = '0;
                end
            end
            S_UP, S_DOWN: begin
                w_dir = (r_state == S_UP);
                if (w_press[1]) begin
                    // Pause beats a coincident tick; the step lands after resume.
                    w_state_nxt    = S_PAUSE;
                    w_saved_up_nxt = (r_state == S_UP);
                end else begin
                    w_presc_nxt = w_tick ? '0 : r_presc + 1'b1;
                    if (w_tick) begin
                        if (r_state == S_UP) begin
                            if (r_led == c_led_max) w_state_nxt = S_DOWN;
                            else                    w_led_nxt   = r_led + 1'b1;
                        end else if (r_led == '0) begin
                            w_sweep_nxt = w_sweep_inc;
                            if (SWEEPS != 0 && w_sweep_inc == c_sweeps) begin
                                w_state_nxt = S_IDLE;
                                w_done_nxt  = 1'b1;
                            end else begin
                                w_state_nxt = S_UP;
                            end
                        end else begin
                            w_led_nxt = r_led - 1'b1;
                        end
                    end
                end
            end
            S_PAUSE: begin
                w_dir = r_saved_up;
                if (w_press[1]) w_state_nxt = r_saved_up ? S_UP : S_DOWN;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.led       = r_led;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.dir       = w_dir;
    assign bus.done      = r_done;
    assign bus.sweep_cnt = r_sweep;

endmodule

`default_nettype wire

// File: tb/tb_sweep_sequencer.sv
// ============================================================================
// Module  : tb_sweep_sequencer
// Brief   : Directed vector bench for sweep_sequencer (WIDTH=4, TICK_DIV=4, SWEEPS=2).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sweep_sequencer;

    logic clk = 1'b0;
    logic rst_btn;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    sweep_sequencer_if #(.WIDTH(4)) bus ();

    sweep_sequencer #(
        .WIDTH    (4),
        .TICK_DIV (4),
        .SWEEPS   (2)
`ifdef SWEEP_DEBOUNCE_EN
        ,
        .DEBOUNCE_CYCLES (8)
`endif
    ) dut (
        .clk     (clk),
        .rst_btn (rst_btn),
        .bus     (bus.slave)
    );

    typedef struct {
        logic       go;
        logic       pause;
        int         cycles;
        logic [3:0] led;
        logic       busy;
        logic       dir;
        logic [7:0] sweep;
        logic       done;
    } vec_t;

    vec_t vecs[17];

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [3:0] led, input logic busy,
                         input logic dir, input logic [7:0] sweep, input logic done);
        n_cmp++;
        if ({bus.led, bus.busy, bus.dir, bus.sweep_cnt, bus.done} !== {led, busy, dir, sweep, done}) begin
            n_fail++;
            $display("FAIL %s: got led=%0d busy=%b dir=%b sweep=%0d done=%b, want led=%0d busy=%b dir=%b sweep=%0d done=%b",
                     name, bus.led, bus.busy, bus.dir, bus.sweep_cnt, bus.done,
                     led, busy, dir, sweep, done);
        end
    endtask

    task automatic check_busy(input string name, input logic busy);
        n_cmp++;
        if (bus.busy !== busy) begin
            n_fail++;
            $display("FAIL %s: got busy=%b, want busy=%b", name, bus.busy, busy);
        end
    endtask

    initial begin
        bus.go_btn    = 1'b1;
        bus.pause_btn = 1'b1;
        rst_btn       = 1'b0;
        step(2);
        check("reset_hold", 4'd0, 1'b0, 1'b1, 8'd0, 1'b0);
        rst_btn = 1'b1;
        step(3);
        check("reset_release", 4'd0, 1'b0, 1'b1, 8'd0, 1'b0);

`ifdef SWEEP_DEBOUNCE_EN
        bus.go_btn = 1'b0;
        step(5);
        bus.go_btn = 1'b1;
        step(20);
        check_busy("deb_glitch", 1'b0);
        bus.go_btn = 1'b0;
        step(12);
        bus.go_btn = 1'b1;
        step(5);
        check_busy("deb_press", 1'b1);
        step(30);
        check_busy("deb_still_run", 1'b1);
`else
        // k = clocks since entry to UP; led steps on every 4th clock.
        vecs[0]  = '{1'b1, 1'b1,   2, 4'd0,  1'b0, 1'b1, 8'd0, 1'b0}; // idle
        vecs[1]  = '{1'b1, 1'b0,   3, 4'd0,  1'b0, 1'b1, 8'd0, 1'b0}; // pause in IDLE ignored
        vecs[2]  = '{1'b1, 1'b1,   3, 4'd0,  1'b0, 1'b1, 8'd0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1,   3, 4'd0,  1'b1, 1'b1, 8'd0, 1'b0}; // go -> UP, k=0
        vecs[4]  = '{1'b1, 1'b1,   5, 4'd1,  1'b1, 1'b1, 8'd0, 1'b0}; // k=5
        vecs[5]  = '{1'b1, 1'b1,  15, 4'd5,  1'b1, 1'b1, 8'd0, 1'b0}; // k=20
        vecs[6]  = '{1'b0, 1'b1,   3, 4'd5,  1'b1, 1'b1, 8'd0, 1'b0}; // go while busy, k=23
        vecs[7]  = '{1'b1, 1'b1,  13, 4'd9,  1'b1, 1'b1, 8'd0, 1'b0}; // k=36
        vecs[8]  = '{1'b1, 1'b1,  27, 4'd15, 1'b1, 1'b1, 8'd0, 1'b0}; // k=63
        vecs[9]  = '{1'b1, 1'b1,   1, 4'd15, 1'b1, 1'b0, 8'd0, 1'b0}; // dwell at max
        vecs[10] = '{1'b1, 1'b1,   4, 4'd14, 1'b1, 1'b0, 8'd0, 1'b0}; // k=68
        vecs[11] = '{1'b1, 1'b1,  56, 4'd0,  1'b1, 1'b0, 8'd0, 1'b0}; // k=124
        vecs[12] = '{1'b1, 1'b1,   4, 4'd0,  1'b1, 1'b1, 8'd1, 1'b0}; // k=128 sweep 1
        vecs[13] = '{1'b1, 1'b1,   4, 4'd1,  1'b1, 1'b1, 8'd1, 1'b0}; // k=132
        vecs[14] = '{1'b1, 1'b1, 123, 4'd0,  1'b1, 1'b0, 8'd1, 1'b0}; // k=255
        vecs[15] = '{1'b1, 1'b1,   1, 4'd0,  1'b0, 1'b1, 8'd2, 1'b1}; // k=256 done
        vecs[16] = '{1'b1, 1'b1,   1, 4'd0,  1'b0, 1'b1, 8'd2, 1'b0}; // done is 1 cycle

        for (int i = 0; i < 17; i++) begin
            bus.go_btn    = vecs[i].go;
            bus.pause_btn = vecs[i].pause;
            step(vecs[i].cycles);
            check($sformatf("vec%0d", i), vecs[i].led, vecs[i].busy, vecs[i].dir,
                  vecs[i].sweep, vecs[i].done);
        end

        // go + pause together in IDLE: go wins
        bus.go_btn    = 1'b0;
        bus.pause_btn = 1'b0;
        step(3);
        check("go_pause_same", 4'd0, 1'b1, 1'b1, 8'd0, 1'b0);
        bus.go_btn    = 1'b1;
        bus.pause_btn = 1'b1;
        step(5);
        check("run_after_both", 4'd1, 1'b1, 1'b1, 8'd0, 1'b0);

        // pause at led=5 going up
        step(15);
        bus.pause_btn = 1'b0;
        step(3);
        check("pause_enter", 4'd5, 1'b1, 1'b1, 8'd0, 1'b0);
        bus.pause_btn = 1'b1;
        step(100);
        check("pause_hold", 4'd5, 1'b1, 1'b1, 8'd0, 1'b0);
        bus.pause_btn = 1'b0;
        step(3);
        check("resume", 4'd5, 1'b1, 1'b1, 8'd0, 1'b0);
        bus.pause_btn = 1'b1;
        step(2);
        check("resume_step", 4'd6, 1'b1, 1'b1, 8'd0, 1'b0);

        // pause lands on a tick edge: step suppressed, applied right after resume
        step(1);
        bus.pause_btn = 1'b0;
        step(3);
        check("pause_on_tick", 4'd6, 1'b1, 1'b1, 8'd0, 1'b0);
        bus.pause_btn = 1'b1;
        step(5);
        bus.pause_btn = 1'b0;
        step(3);
        check("resume_on_tick", 4'd6, 1'b1, 1'b1, 8'd0, 1'b0);
        bus.pause_btn = 1'b1;
        step(1);
        check("tick_after_resume", 4'd7, 1'b1, 1'b1, 8'd0, 1'b0);

        // run to led=9 counting down, then async reset between edges
        step(60);
        check("down_at_9", 4'd9, 1'b1, 1'b0, 8'd0, 1'b0);
        #2;
        rst_btn = 1'b0;
        #1;
        check("async_reset", 4'd0, 1'b0, 1'b1, 8'd0, 1'b0);
        rst_btn = 1'b1;
        step(2);
        check("after_reset", 4'd0, 1'b0, 1'b1, 8'd0, 1'b0);
        bus.go_btn = 1'b0;
        step(3);
        check("restart", 4'd0, 1'b1, 1'b1, 8'd0, 1'b0);
        bus.go_btn = 1'b1;
        step(4);
        check("restart_step", 4'd1, 1'b1, 1'b1, 8'd0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
